acc_seq_ctrl: RTL and testbench

ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

---
 rtl/acc_ctrl_pkg.sv | 15 +
 rtl/acc_seq_ctrl_if.sv | 33 +++
 rtl/acc_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_acc_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_ctrl_pkg.sv
// rtl/acc_ctrl_pkg.sv - state encoding and parameter defaults for acc_seq_ctrl
package acc_ctrl_pkg;

  localparam int VEC_W_DEF = 256;
  localparam int LEN_W_DEF = 8;
  localparam int TMO_DEF   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// rtl/acc_seq_ctrl_if.sv - upstream, accumulator-side and downstream vector signals
interface acc_seq_ctrl_if
  import acc_ctrl_pkg::*;
#(
  parameter int VEC_W = VEC_W_DEF
);

  logic             s_valid;
  logic             s_ready;
  logic [VEC_W-1:0] s_vector;

  logic             acc_in_valid;
  logic [VEC_W-1:0] acc_in_vector;
  logic             acc_in_accum_done;
  logic             acc_out_valid;
  logic [VEC_W-1:0] acc_out_vector;

  logic             m_valid;
  logic             m_ready;
  logic [VEC_W-1:0] m_vector;

  // slave: the sequencer itself; master: its surroundings
  modport slave (
    input  s_valid, s_vector, acc_out_valid, acc_out_vector, m_ready,
    output s_ready, acc_in_valid, acc_in_vector, acc_in_accum_done, m_valid, m_vector
  );

  modport master (
    output s_valid, s_vector, acc_out_valid, acc_out_vector, m_ready,
    input  s_ready, acc_in_valid, acc_in_vector, acc_in_accum_done, m_valid, m_vector
  );

endinterface

// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - sequences partial-sum vectors into an external accumulator and returns its result
module acc_seq_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int VEC_W = VEC_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int TMO   = TMO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err_len,
  output logic             err_tmo,
  acc_seq_ctrl_if.slave    bus
);

  localparam int TMR_W = $clog2(TMO + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_len_q;
  logic [LEN_W-1:0]   r_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic               r_acc_in_valid;
  logic [VEC_W-1:0]   r_acc_in_vector;
  logic               r_acc_in_done;
  logic               r_m_valid;
  logic [VEC_W-1:0]   r_m_vector;
  logic               r_done;
  logic               r_err_len;
  logic               r_err_tmo;

  logic               w_hs;
  logic               w_last;
  logic               w_tmo;

  assign w_hs   = bus.s_valid && (r_state == ST_ACCUM);
  assign w_last = (r_cnt == r_len_q - 1'b1);
  assign w_tmo  = (r_timer == TMR_W'(TMO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && (cfg_len != '0)) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_hs && w_last)           w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // a result arriving on the final timer cycle still wins over the timeout
        if (bus.acc_out_valid) w_state_nxt = ST_OUT;
        else if (w_tmo)        w_state_nxt = ST_IDLE;
      end
      ST_OUT:   if (bus.m_ready)              w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_q         <= '0;
      r_cnt           <= '0;
      r_timer         <= '0;
      r_acc_in_valid  <= 1'b0;
      r_acc_in_vector <= '0;
      r_acc_in_done   <= 1'b0;
      r_m_valid       <= 1'b0;
      r_m_vector      <= '0;
      r_done          <= 1'b0;
      r_err_len       <= 1'b0;
      r_err_tmo       <= 1'b0;
    end else begin
      r_acc_in_valid <= 1'b0;
      r_acc_in_done  <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && (cfg_len != '0)) begin
            r_len_q <= cfg_len;
            r_cnt   <= '0;
          end else if (start) begin
            r_err_len <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (w_hs) begin
            r_acc_in_valid  <= 1'b1;
            r_acc_in_vector <= bus.s_vector;
            r_acc_in_done   <= w_last;
            // cnt stops at len_q on the last handshake, so it cannot wrap
            r_cnt           <= r_cnt + 1'b1;
            if (w_last) r_timer <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.acc_out_valid) begin
            r_m_vector <= bus.acc_out_vector;
            r_m_valid  <= 1'b1;
          end else if (w_tmo) begin
            r_err_tmo <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy                  = (r_state != ST_IDLE);
  assign done                  = r_done;
  assign err_len               = r_err_len;
  assign err_tmo               = r_err_tmo;
  assign bus.s_ready           = (r_state == ST_ACCUM);
  assign bus.acc_in_valid      = r_acc_in_valid;
  assign bus.acc_in_vector     = r_acc_in_vector;
  assign bus.acc_in_accum_done = r_acc_in_done;
  assign bus.m_valid           = r_m_valid;
  assign bus.m_vector          = r_m_vector;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb/tb_acc_seq_ctrl.sv - randomized self-checking bench for acc_seq_ctrl
module tb_acc_seq_ctrl;
  import acc_ctrl_pkg::*;

  localparam int VW = 256;
  localparam int LW = 8;
  localparam int TM = 64;

  typedef logic [VW-1:0] vec_t;
  typedef struct packed {
    logic last;
    vec_t v;
  } accin_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] cfg_len;
  logic          start;
  logic          busy, done, err_len, err_tmo;

  acc_seq_ctrl_if #(.VEC_W(VW)) bus ();

  acc_seq_ctrl #(.VEC_W(VW), .LEN_W(LW), .TMO(TM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_len (cfg_len),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err_len (err_len),
    .err_tmo (err_tmo),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  bit     e_err_len = 0;
  bit     e_err_tmo = 0;
  accin_t q_obs[$];
  int     n_done = 0;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.acc_in_valid) q_obs.push_back({bus.acc_in_accum_done, bus.acc_in_vector});
    if (done) n_done++;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   vec_t'(busy), '0);
    chk({tag, "_done"},   vec_t'(done), '0);
    chk({tag, "_errlen"}, vec_t'(err_len), '0);
    chk({tag, "_errtmo"}, vec_t'(err_tmo), '0);
    chk({tag, "_sready"}, vec_t'(bus.s_ready), '0);
    chk({tag, "_aiv"},    vec_t'(bus.acc_in_valid), '0);
    chk({tag, "_aivec"},  bus.acc_in_vector, '0);
    chk({tag, "_aidone"}, vec_t'(bus.acc_in_accum_done), '0);
    chk({tag, "_mvalid"}, vec_t'(bus.m_valid), '0);
    chk({tag, "_mvec"},   bus.m_vector, '0);
  endtask

  // one accumulation: p<0 means s_valid alternates 1,0,1,...; d = cycles before the result; r = m_ready stall
  task automatic run(input int len, input int p, input int d, input int r, input vec_t res);
    vec_t exp_q[$];
    int   sent;
    int   it;
    int   done0;
    bit   tog;
    bit   v;
    bit   ok;
    sent  = 0;
    it    = 0;
    tog   = 1'b1;
    done0 = n_done;
    q_obs.delete();

    cfg_len = LW'(len);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cfg_len = LW'($urandom);
    chk("busy_start", vec_t'(busy), vec_t'(1));

    while (sent < len && it < 400) begin
      v   = (p < 0) ? tog : ($urandom_range(99) < p);
      tog = ~tog;
      bus.s_valid  = v;
      bus.s_vector = {8{$urandom}};
      if (v && bus.s_ready) begin
        exp_q.push_back(bus.s_vector);
        sent++;
      end
      @(negedge clk);
      it++;
    end
    chk("feed_count", vec_t'(sent), vec_t'(len));

    ok = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < d; i++) begin
      if (bus.s_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    chk("s_ready_wait", vec_t'(ok), vec_t'(1));
    bus.s_valid = 1'b0;

    bus.acc_out_valid  = 1'b1;
    bus.acc_out_vector = res;
    @(negedge clk);
    bus.acc_out_valid  = 1'b0;
    bus.acc_out_vector = {8{$urandom}};

    if (d >= TM) begin
      e_err_tmo = 1'b1;
      chk("tmo_idle", vec_t'(busy), '0);
      chk("tmo_mvalid", vec_t'(bus.m_valid), '0);
    end else begin
      chk("m_valid", vec_t'(bus.m_valid), vec_t'(1));
      chk("m_vector", bus.m_vector, res);
      ok = 1'b1;
      for (int i = 0; i < r; i++) begin
        if (i == r / 2) begin
          start   = 1'b1;
          cfg_len = LW'(1);
        end
        @(negedge clk);
        start = 1'b0;
        if (bus.m_valid !== 1'b1 || bus.m_vector !== res) ok = 1'b0;
      end
      chk("out_hold", vec_t'(ok), vec_t'(1));
      bus.m_ready = 1'b1;
      start       = 1'b1;
      cfg_len     = LW'(3);
      @(negedge clk);
      bus.m_ready = 1'b0;
      start       = 1'b0;
      chk("m_valid_drop", vec_t'(bus.m_valid), '0);
      chk("done_pulse", vec_t'(done), vec_t'(1));
      chk("idle_after", vec_t'(busy), '0);
      @(negedge clk);
      chk("done_once", vec_t'(done), '0);
      chk("start_ignored", vec_t'(busy), '0);
    end

    chk("acc_in_count", vec_t'(q_obs.size()), vec_t'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < q_obs.size()) begin
        chk("acc_in_vec", q_obs[i].v, exp_q[i]);
        chk("acc_in_last", vec_t'(q_obs[i].last), vec_t'(i == len - 1));
      end
    end
    chk("done_count", vec_t'(n_done - done0), vec_t'((d < TM) ? 1 : 0));
    chk("err_len_st", vec_t'(err_len), vec_t'(e_err_len));
    chk("err_tmo_st", vec_t'(err_tmo), vec_t'(e_err_tmo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int   done0;
    vec_t r;
    cfg_len            = '0;
    start              = 1'b0;
    bus.s_valid        = 1'b0;
    bus.s_vector       = '0;
    bus.acc_out_valid  = 1'b0;
    bus.acc_out_vector = '0;
    bus.m_ready        = 1'b0;

    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run(4, 100, 2, 5, {16{16'h3C00}});
    r = {8{$urandom}};
    run(3, -1, 4, 1, r);
    r = {8{$urandom}};
    run(1, 100, TM - 1, 0, r);

    cfg_len = '0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    e_err_len = 1'b1;
    chk("zero_len_err", vec_t'(err_len), vec_t'(1));
    chk("zero_len_idle", vec_t'(busy), '0);
    @(negedge clk);
    chk("zero_len_stay", vec_t'(busy), '0);

    r = {8{$urandom}};
    run(2, 100, TM + 6, 0, r);

    for (int k = 0; k < 8; k++) begin
      r = {8{$urandom}};
      run($urandom_range(1, 6), $urandom_range(30, 100),
          ($urandom_range(0, 5) == 0) ? TM + 2 : $urandom_range(0, 10),
          $urandom_range(0, 4), r);
    end

    q_obs.delete();
    done0   = n_done;
    cfg_len = LW'(5);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_vector = {8{$urandom}};
    @(negedge clk);
    bus.s_vector = {8{$urandom}};
    @(negedge clk);
    bus.s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    chk("midrst_pulses", vec_t'(q_obs.size()), vec_t'(2));
    if (q_obs.size() == 2) chk("midrst_nolast", vec_t'(q_obs[1].last), '0);
    @(negedge clk);
    chk("midrst_nodone", vec_t'(n_done - done0), '0);
    rst_n = 1'b1;
    e_err_len = 1'b0;
    e_err_tmo = 1'b0;
    @(negedge clk);
    r = {8{$urandom}};
    run(1, 100, 3, 2, r);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
